// File: rtl/ev_bcd_display_if.sv
// rtl/ev_bcd_display_if.sv - value handshake, BCD result and display bundle
interface ev_bcd_display_if;
    logic [7:0]  value_in;
    logic        value_valid;
    logic        busy;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    modport master (
        output value_in,
        output value_valid,
        input  busy,
        input  bcd_out,
        input  bcd_valid,
        input  seg,
        input  digit_en
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output busy,
        output bcd_out,
        output bcd_valid,
        output seg,
        output digit_en
    );
endinterface

// File: rtl/ev_bcd_display.sv
// rtl/ev_bcd_display.sv - 8-bit binary to 3-digit BCD converter with multiplexed 7-segment scan
module ev_bcd_display #(
    parameter int SCAN_DIV_W = 10,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    ev_bcd_display_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic [11:0] scratch_adj;
    logic [2:0]  bit_cnt_q;
    logic [11:0] bcd_q;
    logic        bcd_valid_q;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.value_valid) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt_q == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign scratch_adj = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};

    // Double-dabble: adjust digits first, then shift the combined scratch/source register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= 8'd0;
            scratch_q   <= 12'd0;
            bit_cnt_q   <= 3'd0;
            bcd_q       <= 12'd0;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.value_valid) begin
                        shift_q   <= bus.value_in;
                        scratch_q <= 12'd0;
                        bit_cnt_q <= 3'd0;
                    end
                end
                SHIFT: begin
                    {scratch_q, shift_q} <= {scratch_adj[10:0], shift_q, 1'b0};
                    bit_cnt_q            <= bit_cnt_q + 3'd1;
                end
                DONE: begin
                    bcd_q       <= scratch_q;
                    bcd_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.bcd_out   = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;

    logic [SCAN_DIV_W-1:0] presc_q;
    logic [1:0]            digit_idx_q;
    logic [3:0]            digit_sel;
    logic                  blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            digit_idx_q <= 2'd0;
        end else begin
            presc_q <= presc_q + SCAN_DIV_W'(1);
            if (&presc_q) begin
                digit_idx_q <= (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
            end
        end
    end

    always_comb begin
        bus.digit_en = 3'b001;
        digit_sel    = bcd_q[3:0];
        case (digit_idx_q)
            2'd1: begin
                bus.digit_en = 3'b010;
                digit_sel    = bcd_q[7:4];
            end
            2'd2: begin
                bus.digit_en = 3'b100;
                digit_sel    = bcd_q[11:8];
            end
            default: ;
        endcase
    end

    // Seg is decoded straight from bcd_q so all digits switch on the same edge.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            if (digit_idx_q == 2'd2 && bcd_q[11:8] == 4'd0) blank = 1'b1;
            if (digit_idx_q == 2'd1 && bcd_q[11:4] == 8'd0) blank = 1'b1;
        end
        bus.seg = blank ? 7'h00 : seg_lut(digit_sel);
    end

endmodule

// File: tb/tb_ev_bcd_display.sv
// tb/tb_ev_bcd_display.sv - randomized and directed checks of ev_bcd_display against a value-level model
module tb_ev_bcd_display;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ev_bcd_display_if ifa ();
    ev_bcd_display_if ifb ();
    ev_bcd_display_if ifc ();

    ev_bcd_display #(.SCAN_DIV_W(2), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    ev_bcd_display #(.SCAN_DIV_W(2), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    ev_bcd_display dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int m_left  = 0;
    int m_pend  = 0;
    int m_val   = 0;
    bit m_pulse = 1'b0;
    int cyc     = 0;
    int pulses  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic logic [31:0] exp_seg(input int v, input int idx, input bit blank_lz);
        int d;
        d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
        if (blank_lz && idx == 2 && v < 100) return 32'h0;
        if (blank_lz && idx == 1 && v < 10) return 32'h0;
        return 32'(lut[d]);
    endfunction

    task automatic step(input bit r, input bit vv, input int v);
        int ia;
        int ic;
        rst = r;
        ifa.value_valid = vv; ifa.value_in = 8'(v);
        ifb.value_valid = vv; ifb.value_in = 8'(v);
        ifc.value_valid = vv; ifc.value_in = 8'(v);
        @(posedge clk);
        if (r) begin
            m_left = 0; m_val = 0; m_pulse = 1'b0; cyc = 0;
        end else begin
            m_pulse = 1'b0;
            cyc++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val   = m_pend;
                    m_pulse = 1'b1;
                end
            end else if (vv) begin
                m_left = 9;
                m_pend = v;
            end
        end
        #1;
        if (ifa.bcd_valid === 1'b1) pulses++;
        ia = (cyc / 4) % 3;
        ic = (cyc / 1024) % 3;
        check("busy",      32'(ifa.busy),      32'(m_left != 0));
        check("bcd_valid", 32'(ifa.bcd_valid), 32'(m_pulse));
        check("bcd_out",   32'(ifa.bcd_out),   to_bcd(m_val));
        check("bcd_out_b", 32'(ifb.bcd_out),   to_bcd(m_val));
        check("bcd_out_c", 32'(ifc.bcd_out),   to_bcd(m_val));
        check("digit_en",  32'(ifa.digit_en),  32'(1 << ia));
        check("seg",       32'(ifa.seg),       exp_seg(m_val, ia, 1'b1));
        check("seg_nolz",  32'(ifb.seg),       exp_seg(m_val, ia, 1'b0));
        check("digit_en_c", 32'(ifc.digit_en), 32'(1 << ic));
        check("seg_c",     32'(ifc.seg),       exp_seg(m_val, ic, 1'b1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        int bvals [5] = '{0, 9, 10, 99, 100};
        ifa.value_valid = 1'b0; ifa.value_in = 8'd0;
        ifb.value_valid = 1'b0; ifb.value_in = 8'd0;
        ifc.value_valid = 1'b0; ifc.value_in = 8'd0;

        // reset held two cycles, valid asserted to confirm reset priority
        step(1'b1, 1'b1, 200);
        step(1'b1, 1'b1, 200);
        idle(3);

        // full scale, then long hold so the default-width scan cycles all digits
        step(1'b0, 1'b1, 255);
        idle(3200);

        // blanking on a single-digit value
        step(1'b0, 1'b1, 7);
        idle(30);

        // drop while busy, then accept at first free cycle
        step(1'b0, 1'b1, 100);
        idle(2);
        step(1'b0, 1'b1, 42);
        idle(6);
        step(1'b0, 1'b1, 42);
        idle(12);

        // reset mid-conversion
        step(1'b0, 1'b1, 99);
        idle(3);
        step(1'b1, 1'b0, 0);
        idle(4);
        step(1'b0, 1'b1, 99);
        idle(12);

        // boundaries back to back
        pulses = 0;
        foreach (bvals[k]) begin
            step(1'b0, 1'b1, bvals[k]);
            idle(9);
        end
        idle(2);
        check("boundary_pulses", 32'(pulses), 32'd5);

        // random traffic with rare resets
        for (int i = 0; i < 3500; i++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
